// File: rtl/neuron_pkg.sv
// Shared constants and feeder state encoding for the neuron inference unit.
package neuron_pkg;

  // Sample format: signed fixed point, 1 sign, 3 integer, 8 fraction bits.
  localparam int SIGN_W  = 1;
  localparam int INT_W   = 3;
  localparam int FRAC_W  = 8;
  localparam int NRN_I_W = SIGN_W + INT_W + FRAC_W;
  localparam int NRN_O_W = 23;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLR,
    ST_STREAM,
    ST_WAIT,
    ST_HOLD
  } feeder_state_t;

endpackage

// File: rtl/neuron_feeder_buf.sv
// Sample buffer: N_INPUTS x I_W register file, synchronous write, asynchronous read, no reset.
module neuron_feeder_buf
  import neuron_pkg::*;
#(
  parameter int N_INPUTS = 4,
  parameter int I_W      = NRN_I_W,
  parameter int AW       = 2
) (
  input  logic           clk,
  input  logic           we,
  input  logic [AW-1:0]  waddr,
  input  logic [I_W-1:0] wdata,
  input  logic [AW-1:0]  raddr,
  output logic [I_W-1:0] rdata
);

  logic [I_W-1:0] mem [N_INPUTS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/neuron_feeder.sv
// Neuron feeder: buffers a sample vector, clears and streams it to the neuron,
// then captures the neuron result after a fixed latency and offers it downstream.
module neuron_feeder
  import neuron_pkg::*;
#(
  parameter int N_INPUTS = 4,
  parameter int I_W      = NRN_I_W,
  parameter int O_W      = NRN_O_W,
  parameter int NRN_LAT  = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [I_W-1:0] s_data,
  output logic           nrn_clr,
  output logic           nrn_valid,
  output logic [I_W-1:0] nrn_data,
  output logic           nrn_last,
  input  logic [O_W-1:0] nrn_out,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [O_W-1:0] res_data
);

  localparam int CW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int WW = ($clog2(NRN_LAT + 1) > 1) ? $clog2(NRN_LAT + 1) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N_INPUTS - 1);
  localparam logic [WW-1:0] LAT_END  = WW'(NRN_LAT);

  feeder_state_t  state;
  logic [CW-1:0]  wr_cnt;
  logic [CW-1:0]  rd_cnt;
  logic [WW-1:0]  wait_cnt;
  logic [CW-1:0]  raddr;
  logic [I_W-1:0] rdata;
  logic           wr_en;

  // Both streams use plain valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; ready depends only on state, never on valid.
  assign s_ready   = (state == ST_LOAD);
  assign nrn_clr   = (state == ST_CLR);
  assign nrn_valid = (state == ST_STREAM);
  assign nrn_last  = (state == ST_STREAM) && (rd_cnt == LAST_IDX);
  assign res_valid = (state == ST_HOLD);
  assign wr_en     = s_ready && s_valid;

  // Prefetch address: next sample to be registered onto nrn_data.
  always_comb begin
    raddr = '0;
    if (state == ST_STREAM && rd_cnt != LAST_IDX) raddr = rd_cnt + CW'(1);
  end

  neuron_feeder_buf #(
    .N_INPUTS (N_INPUTS),
    .I_W      (I_W),
    .AW       (CW)
  ) u_sample_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_cnt),
    .wdata (s_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      wait_cnt <= '0;
      nrn_data <= '0;
      res_data <= '0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_LOAD;
        ST_LOAD: begin
          if (s_valid) begin
            if (wr_cnt == LAST_IDX) begin
              wr_cnt <= '0;
              state  <= ST_CLR;
            end else begin
              wr_cnt <= wr_cnt + CW'(1);
            end
          end
        end
        ST_CLR: begin
          nrn_data <= rdata;
          state    <= ST_STREAM;
        end
        ST_STREAM: begin
          if (rd_cnt == LAST_IDX) begin
            rd_cnt   <= '0;
            wait_cnt <= WW'(1);
            state    <= ST_WAIT;
          end else begin
            rd_cnt   <= rd_cnt + CW'(1);
            nrn_data <= rdata;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == LAT_END) begin
            res_data <= nrn_out;
            wait_cnt <= '0;
            state    <= ST_HOLD;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        ST_HOLD: begin
          if (res_ready) state <= ST_LOAD;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_feeder.sv
// Directed bench for neuron_feeder with a behavioural neuron and result/sample scoreboards.
module tb_neuron_feeder;

  localparam int N       = 4;
  localparam int LAT     = 2;
  localparam int LATENCY = 1 + N + LAT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [11:0] s_data = '0;
  logic        nrn_clr;
  logic        nrn_valid;
  logic [11:0] nrn_data;
  logic        nrn_last;
  logic [22:0] nrn_out;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [22:0] res_data;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int clr_cnt = 0;
  int strm_cnt = 0;
  int acc_cnt = 0;
  int hold_cnt = 0;
  int strm_idx = 0;
  bit hs_pend = 0;
  bit res_valid_q = 0;

  logic [22:0] exp_q[$];
  logic [11:0] samp_q[$];

  logic [22:0] acc = '0;
  logic [22:0] acc_d = '0;

  neuron_feeder #(
    .N_INPUTS (N),
    .I_W      (12),
    .O_W      (23),
    .NRN_LAT  (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .nrn_clr   (nrn_clr),
    .nrn_valid (nrn_valid),
    .nrn_data  (nrn_data),
    .nrn_last  (nrn_last),
    .nrn_out   (nrn_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Neuron model: clearable sum of zero-extended samples, result visible LAT cycles on.
  always @(posedge clk) begin
    if (nrn_clr) acc <= '0;
    else if (nrn_valid) acc <= acc + 23'(nrn_data);
    acc_d <= acc;
  end
  assign nrn_out = acc_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] d, input bit last);
    int t;
    bit rdy;
    s_valid = 1'b1;
    s_data  = d;
    t = 0;
    do begin
      rdy = s_ready;
      step();
      t++;
    end while (!rdy && t < 200);
    s_valid = 1'b0;
    if (rdy) begin
      samp_q.push_back(d);
      if (last) last_acc_cyc = cyc;
    end else begin
      check("send_accept", 32'(rdy), 32'd1);
    end
  endtask

  task automatic send_vec(input logic [11:0] v [N], input int gap);
    logic [22:0] sum;
    sum = '0;
    for (int i = 0; i < N; i++) sum = sum + 23'(v[i]);
    exp_q.push_back(sum);
    for (int i = 0; i < N; i++) begin
      send(v[i], i == N - 1);
      if (i != N - 1) repeat (gap) step();
    end
  endtask

  task automatic wait_res(input string tag);
    int t;
    t = 0;
    while (!res_valid && t < 200) begin
      step();
      t++;
    end
    check(tag, 32'(res_valid), 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      step();
      t++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_s_ready"},   32'(s_ready),   32'd0);
    check({tag, "_nrn_clr"},   32'(nrn_clr),   32'd0);
    check({tag, "_nrn_valid"}, 32'(nrn_valid), 32'd0);
    check({tag, "_nrn_data"},  32'(nrn_data),  32'd0);
    check({tag, "_nrn_last"},  32'(nrn_last),  32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_data"},  32'(res_data),  32'd0);
  endtask

  // Monitor / scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    logic [11:0] e_s;
    logic [22:0] e_r;
    if (rst) begin
      strm_idx    = 0;
      hs_pend     = 0;
      res_valid_q = 0;
    end else begin
      if (hs_pend) begin
        check("hold_to_load", 32'({s_ready, res_valid}), 32'd2);
        hs_pend = 0;
      end
      if (nrn_clr) clr_cnt++;
      if (s_valid && s_ready) acc_cnt++;
      if (nrn_valid) begin
        strm_cnt++;
        if (samp_q.size() > 0) begin
          e_s = samp_q.pop_front();
          check("nrn_data", 32'(nrn_data), 32'(e_s));
        end else begin
          check("stream_unexpected", 32'(nrn_valid), 32'd0);
        end
        check("nrn_last", 32'(nrn_last), 32'(strm_idx == N - 1));
        strm_idx = (strm_idx == N - 1) ? 0 : strm_idx + 1;
      end
      if (res_valid && !res_valid_q) check("latency", 32'(cyc - last_acc_cyc), 32'(LATENCY));
      if (res_valid) hold_cnt++;
      if (res_valid && res_ready) begin
        if (exp_q.size() > 0) begin
          e_r = exp_q.pop_front();
          check("res_data", 32'(res_data), 32'(e_r));
        end else begin
          check("result_unexpected", 32'(res_valid), 32'd0);
        end
        hs_pend = 1;
      end
      res_valid_q = res_valid;
    end
  end

  initial begin
    logic [11:0] vec [N];
    int c0, c1, c2, c3;

    // Reset state
    step();
    check_zero_outputs("reset");
    rst = 1'b0;
    check("idle_s_ready", 32'(s_ready), 32'd0);
    step();
    check("load_s_ready", 32'(s_ready), 32'd1);

    // Basic
    res_ready = 1'b1;
    c0 = clr_cnt; c1 = strm_cnt; c2 = hold_cnt;
    vec = '{12'h200, 12'h200, 12'h200, 12'h200};
    send_vec(vec, 0);
    wait_drain("basic_drain");
    step();
    check("basic_clr_pulses", 32'(clr_cnt - c0), 32'd1);
    check("basic_stream_cycles", 32'(strm_cnt - c1), 32'd4);
    check("basic_res_valid_cycles", 32'(hold_cnt - c2), 32'd1);
    check("nrn_data_hold", 32'(nrn_data), 32'h200);

    // Backpressure
    res_ready = 1'b0;
    vec = '{12'h001, 12'h002, 12'h003, 12'h004};
    send_vec(vec, 0);
    wait_res("bp_res_valid");
    for (int i = 0; i < 10; i++) begin
      check("bp_res_valid_hold", 32'(res_valid), 32'd1);
      check("bp_res_data_hold", 32'(res_data), 32'h00000A);
      check("bp_s_ready_low", 32'(s_ready), 32'd0);
      step();
    end
    res_ready = 1'b1;
    step();
    check("bp_s_ready_after", 32'(s_ready), 32'd1);
    wait_drain("bp_drain");

    // Gapped input
    vec = '{12'h100, 12'h200, 12'h300, 12'h400};
    send_vec(vec, 1);
    wait_drain("gap_drain");

    // Ignored input while busy
    res_ready = 1'b0;
    c3 = acc_cnt;
    vec = '{12'h011, 12'h022, 12'h033, 12'h044};
    send_vec(vec, 0);
    s_valid = 1'b1;
    s_data  = 12'hFFF;
    wait_res("ign_res_valid");
    s_valid = 1'b0;
    check("ign_accepts", 32'(acc_cnt - c3), 32'd4);
    res_ready = 1'b1;
    wait_drain("ign_drain");

    // Reset mid-operation
    send(12'h123, 1'b0);
    send(12'h123, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_zero_outputs("midrst");
    samp_q.delete();
    step();
    rst = 1'b0;
    step();
    vec = '{12'h400, 12'h400, 12'h400, 12'h400};
    send_vec(vec, 0);
    wait_drain("midrst_drain");

    // Back-to-back vectors
    vec = '{12'h010, 12'h010, 12'h010, 12'h010};
    send_vec(vec, 0);
    vec = '{12'h020, 12'h020, 12'h020, 12'h020};
    send_vec(vec, 0);
    wait_drain("b2b_drain");
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
